// File: rtl/cnn_pkg.sv
// cnn_pkg: widths, fixed conv/FC weights and FSM type shared by the simple_cnn slice
package cnn_pkg;
  localparam int PIX_W      = 8;
  localparam int K          = 5;
  localparam int OUT_DIM    = 24;
  localparam int N_CLASS    = 10;
  localparam int N_REG      = 9;
  localparam int FEAT_SHIFT = 4;
  localparam int ACC_W      = 22;
  localparam int FEAT_W     = 8;
  localparam int SCORE_W    = 28;

  typedef enum logic [0:0] {IDLE, RUN} state_e;

  localparam logic signed [7:0] CONV_W [K][K] = '{
    '{ 8'sd1,  8'sd2,  8'sd3,  8'sd2,  8'sd1},
    '{ 8'sd0, -8'sd1, -8'sd2, -8'sd1,  8'sd0},
    '{ 8'sd2,  8'sd4,  8'sd8,  8'sd4,  8'sd2},
    '{ 8'sd0, -8'sd1, -8'sd2, -8'sd1,  8'sd0},
    '{ 8'sd1,  8'sd2,  8'sd3,  8'sd2,  8'sd1}
  };

  // Each region column peaks on its own class; class 9 is flat so it wins on uniform images.
  localparam logic signed [7:0] FC_W [N_CLASS][N_REG] = '{
    '{ 8'sd10, -8'sd3,  8'sd2,  8'sd1, -8'sd1,  8'sd0,  8'sd4, -8'sd2,  8'sd3},
    '{-8'sd2,  8'sd12, -8'sd1,  8'sd0,  8'sd3, -8'sd4,  8'sd1,  8'sd2, -8'sd1},
    '{ 8'sd1, -8'sd2,  8'sd15, -8'sd3,  8'sd0,  8'sd2, -8'sd1,  8'sd1,  8'sd0},
    '{ 8'sd0,  8'sd1, -8'sd2,  8'sd11, -8'sd1,  8'sd3,  8'sd2, -8'sd3,  8'sd1},
    '{ 8'sd2,  8'sd0,  8'sd1, -8'sd1,  8'sd14, -8'sd2,  8'sd0,  8'sd1, -8'sd2},
    '{-8'sd1,  8'sd3,  8'sd0,  8'sd2, -8'sd3,  8'sd13, -8'sd1,  8'sd0,  8'sd2},
    '{ 8'sd3, -8'sd1,  8'sd2,  8'sd0,  8'sd1, -8'sd1,  8'sd16, -8'sd2,  8'sd0},
    '{ 8'sd0,  8'sd2, -8'sd1,  8'sd3,  8'sd0,  8'sd1, -8'sd2,  8'sd12,  8'sd1},
    '{-8'sd3,  8'sd1,  8'sd0, -8'sd2,  8'sd2,  8'sd0,  8'sd3, -8'sd1,  8'sd17},
    '{ 8'sd5,  8'sd5,  8'sd5,  8'sd5,  8'sd5,  8'sd5,  8'sd5,  8'sd5,  8'sd5}
  };
endpackage

// File: rtl/conv5x5_relu.sv
// conv5x5_relu: 5x5 signed-weight convolution of one unsigned patch, ReLU, shift and saturate
module conv5x5_relu
  import cnn_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [K*K*PIX_W-1:0]   patch_i,
  output logic [FEAT_W-1:0]      feat_o
);
  logic signed [ACC_W-1:0] acc_d;
  logic [FEAT_W-1:0]       feat_d;

  always_comb begin
    acc_d = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        acc_d = acc_d + ACC_W'($signed({1'b0, patch_i[(r*K+c)*PIX_W +: PIX_W]})) * ACC_W'(CONV_W[r][c]);
    feat_d = acc_d[ACC_W-1] ? '0 :
             |acc_d[ACC_W-2:FEAT_SHIFT+FEAT_W] ? '1 : acc_d[FEAT_SHIFT +: FEAT_W];
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) feat_o <= '0;
    else feat_o <= feat_d;
endmodule

// File: rtl/simple_cnn.sv
// simple_cnn: streaming conv+ReLU, region-pooled FC into 10 scores, argmax on the last patch
module simple_cnn
  import cnn_pkg::*;
(
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 START,
  input  logic [4:0]           X,
  input  logic [4:0]           Y,
  input  logic [K*K*PIX_W-1:0] IMGIN,
  output logic                 DONE,
  output logic [3:0]           OUT
);
  state_e                    state_q, state_d;
  logic [K*K*PIX_W-1:0]      img_q;
  logic [4:0]                x0_q, y0_q, x1_q, y1_q;
  logic                      v0_q, v0_d, v1_q, last2_q, done_q;
  logic [3:0]                out_q, best_i, region;
  logic [FEAT_W-1:0]         feat;
  logic                      first;
  logic signed [SCORE_W-1:0] score_q [N_CLASS];
  logic signed [SCORE_W-1:0] score_d [N_CLASS];
  logic signed [SCORE_W-1:0] prod, best_v;

  conv5x5_relu u_conv (.clk_i(CLK), .rst_i(nRST), .patch_i(img_q), .feat_o(feat));

  always_comb begin
    state_d = (state_q == IDLE && START) ? RUN : state_q;
    v0_d = state_q == RUN && X < 5'(OUT_DIM) && Y < 5'(OUT_DIM);
    region = 4'(x1_q[4:3]) * 4'd3 + 4'(y1_q[4:3]);
    first = x1_q == '0 && y1_q == '0;
    prod = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      prod = SCORE_W'($signed({1'b0, feat})) * SCORE_W'(FC_W[k][region]);
      score_d[k] = !v1_q ? score_q[k] : first ? prod : score_q[k] + prod;
    end
    // strict compare keeps the lowest index on ties
    best_i = '0;
    best_v = score_q[0];
    for (int k = 1; k < N_CLASS; k++)
      if (score_q[k] > best_v) begin
        best_v = score_q[k];
        best_i = 4'(k);
      end
  end

  always_ff @(posedge CLK or posedge nRST)
    if (nRST) begin
      state_q <= IDLE;
      img_q   <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      last2_q <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      score_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      img_q   <= IMGIN;
      x0_q    <= X;
      y0_q    <= Y;
      v0_q    <= v0_d;
      x1_q    <= x0_q;
      y1_q    <= y0_q;
      v1_q    <= v0_q;
      score_q <= score_d;
      last2_q <= v1_q && x1_q == 5'(OUT_DIM-1) && y1_q == 5'(OUT_DIM-1);
      done_q  <= last2_q;
      out_q   <= last2_q ? best_i : out_q;
    end

  assign DONE = done_q;
  assign OUT  = out_q;
endmodule

// File: tb/tb_simple_cnn.sv
// tb_simple_cnn: directed image streams with hand-computed features, scores, classes and DONE timing
module tb_simple_cnn;
  logic         CLK = 1'b0;
  logic         nRST, START, DONE;
  logic [4:0]   X, Y;
  logic [199:0] IMGIN;
  logic [3:0]   OUT;
  int checks = 0, failures = 0, cyc = 0, done_n = 0, last_t = 0, d0 = 0;
  int done_t [16];
  int done_o [16];

  always #5 CLK = ~CLK;

  simple_cnn dut (.CLK(CLK), .nRST(nRST), .START(START), .X(X), .Y(Y),
                  .IMGIN(IMGIN), .DONE(DONE), .OUT(OUT));

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (DONE === 1'b1) begin
      if (done_n < 16) begin
        done_t[done_n] = cyc;
        done_o[done_n] = int'(OUT);
      end
      done_n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // mode 0: zeros, 1: all 255, 2: all 255 only inside region rj
  function automatic logic [199:0] mk(input int mode, input int rj, input int x, input int y);
    logic [199:0] ones;
    ones = '1;
    return mode == 1 ? ones : (mode == 2 && (x/8)*3 + y/8 == rj) ? ones : '0;
  endfunction

  task automatic run_img(input int mode, input int rj, input int ax, input int ay);
    for (int x = 0; x < 24; x++)
      for (int y = 0; y < 24; y++) begin
        X = 5'(x);
        Y = 5'(y);
        IMGIN = mk(mode, rj, x, y);
        tick();
        if (x == 23 && y == 23) last_t = cyc;
        if (x == ax && y == ay) return;
      end
    X = 5'd31;
    Y = 5'd0;
    IMGIN = '0;
  endtask

  task automatic feat_case(input string tag, input logic [199:0] p, input int exp);
    X = 5'd5;
    Y = 5'd5;
    IMGIN = p;
    tick();
    X = 5'd31;
    tick();
    chk(tag, longint'(dut.u_conv.feat_o), exp);
  endtask

  initial begin
    logic [199:0] p;
    int rj [3] = '{0, 4, 8};
    int sc [3] = '{163200, 228480, 277440};
    nRST = 1'b1;
    START = 1'b0;
    X = 5'd31;
    Y = 5'd0;
    IMGIN = '0;
    idle(2);
    chk("rst_done", DONE, 0);
    chk("rst_out", OUT, 0);
    nRST = 1'b0;
    idle(1);
    START = 1'b1;
    idle(1);
    START = 1'b0;
    // zero image: all scores tie at 0
    d0 = done_n;
    run_img(0, 0, -1, -1);
    idle(5);
    chk("t1_done_cnt", done_n - d0, 1);
    chk("t1_done_lat", done_t[d0] - last_t, 3);
    chk("t1_out", OUT, 0);
    // feature datapath: saturation, plain shift, ReLU clamp
    p = '1;
    feat_case("feat_sat", p, 255);
    p = '0;
    p[12*8 +: 8] = 8'd100;
    feat_case("feat_center", p, 50);
    p = '0;
    p[7*8 +: 8] = 8'd255;
    p[6*8 +: 8] = 8'd255;
    feat_case("feat_relu", p, 0);
    // uniform 255 image: score[k] = 16320 * rowsum(FC_W[k])
    d0 = done_n;
    run_img(1, 0, -1, -1);
    idle(5);
    chk("t2_done_lat", done_t[d0] - last_t, 3);
    chk("t2_out", OUT, 9);
    chk("t2_score9", longint'(dut.score_q[9]), 734400);
    chk("t2_score0", longint'(dut.score_q[0]), 228480);
    chk("t2_score6", longint'(dut.score_q[6]), 293760);
    for (int i = 0; i < 3; i++) begin
      run_img(2, rj[i], -1, -1);
      idle(5);
      chk("reg_out", OUT, rj[i]);
      chk("reg_score", longint'(dut.score_q[rj[i]]), sc[i]);
      chk("reg_score9", longint'(dut.score_q[9]), 81600);
    end
    // back-to-back images; an unreloaded score would keep class 2 ahead
    d0 = done_n;
    run_img(2, 2, -1, -1);
    run_img(2, 7, -1, -1);
    idle(5);
    chk("t3_done_cnt", done_n - d0, 2);
    chk("t3_gap", done_t[d0+1] - done_t[d0], 576);
    chk("t3_out1", done_o[d0], 2);
    chk("t3_out2", done_o[d0+1], 7);
    // reset in the middle of an image
    d0 = done_n;
    run_img(2, 5, 10, 5);
    nRST = 1'b1;
    #1;
    chk("t4_out_async", OUT, 0);
    chk("t4_done_async", DONE, 0);
    X = 5'd31;
    idle(3);
    nRST = 1'b0;
    idle(5);
    chk("t4_no_done", done_n - d0, 0);
    START = 1'b1;
    idle(1);
    START = 1'b0;
    run_img(2, 3, -1, -1);
    idle(5);
    chk("t4_done_cnt", done_n - d0, 1);
    chk("t4_out", OUT, 3);
    // without START nothing is processed
    nRST = 1'b1;
    idle(1);
    nRST = 1'b0;
    d0 = done_n;
    run_img(2, 6, -1, -1);
    idle(5);
    chk("t5_no_done", done_n - d0, 0);
    chk("t5_out", OUT, 0);
    // START held high through RUN is ignored
    START = 1'b1;
    idle(1);
    run_img(2, 1, -1, -1);
    run_img(2, 8, -1, -1);
    idle(5);
    START = 1'b0;
    chk("t5_done_cnt", done_n - d0, 2);
    chk("t5_gap", done_t[d0+1] - done_t[d0], 576);
    chk("t5_out1", done_o[d0], 1);
    chk("t5_out2", done_o[d0+1], 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
